uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-granular round-robin arbiter that shares a single `uart_tx` transmit FIFO among `NUM_CLIENTS` byte-stream requesters. It sits between the client logic (debug console, status reporter, and so on) and the `TxFifoLoad`/`TxData`/`TxFifoFull` write port of `uart_tx`. Each client holds the grant until it ends its packet or hits `MAX_BURST` bytes, so output from different clients is never interleaved mid-packet. An optional one-byte source tag is prepended to every grant.

## Interface
- `NUM_CLIENTS`, default 4: number of requesters; legal range 2..16.
- `MAX_BURST`, default 64: maximum bytes per grant, header excluded; legal range 1..255.
- `ADD_HEADER`, default 1: when 1, the tag byte `8'hA0 | client_index` is written before the first data byte of each grant.
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `ReqValid`  in  NUM_CLIENTS  per-client byte valid.
- `ReqData`  in  8*NUM_CLIENTS  flattened bytes; client i uses `[8i+7:8i]`.
- `ReqLast`  in  NUM_CLIENTS  marks the final byte of a packet; sampled only on an accepted beat.
- `ReqReady`  out  NUM_CLIENTS  per-client accept; a beat transfers when `ReqValid[i] & ReqReady[i]`.
- `TxFifoFull`  in  1  full flag from `uart_tx`.
- `TxFifoLoad`  out  1  write strobe to `uart_tx`.
- `TxData`  out  8  write data to `uart_tx`.
- `Grant`  out  NUM_CLIENTS  one-hot index of the current owner; all zeros when idle.
- `Busy`  out  1  high while any client owns the grant.

## Operation
**States**
- IDLE
  - If any `ReqValid` bit is set, choose the first requester at or after `rrPtr`, wrapping modulo `NUM_CLIENTS`.
  - Register `Grant` one-hot and set `rrPtr <= winner+1`, wrapping.
  - Clear `burstCnt`.
  - Go to HEADER if `ADD_HEADER` is 1, otherwise go to STREAM.
- HEADER
  - `TxData = 8'hA0 | index`; `TxFifoLoad = ~TxFifoFull`; all `ReqReady` are 0.
  - When the load occurs, go to STREAM. Otherwise stay.
- STREAM
  - For granted client g: `ReqReady[g] = ~TxFifoFull`; `TxData = ReqData[g]`; `TxFifoLoad = ReqValid[g] & ~TxFifoFull`.
  - All other `ReqReady` bits are 0.
  - On an accepted beat, `burstCnt <= burstCnt + 1`.
  - If the beat has `ReqLast[g]`, or `burstCnt == MAX_BURST-1`, clear `Grant` and go to IDLE.
- Any unreachable encoding goes to IDLE.

**Registers and widths**
- `rrPtr`: $clog2(NUM_CLIENTS) bits.
- `burstCnt`: 8 bits.

**Output decode**
- `TxData`, `TxFifoLoad` and `ReqReady` are combinational from the registered state, `Grant`, `ReqValid`, `ReqData` and `TxFifoFull`.
- There is no combinational path from `ReqValid` to `ReqReady`.
- `Busy = |Grant`.

**Boundary conditions**
- Granted client deasserts `ReqValid` mid-packet: keep the grant and wait indefinitely. No timeout.
- `TxFifoFull` high: no beat is accepted and no load is issued. State is held, including in HEADER.
- Burst limit reached without `ReqLast`: release the grant. The client's remaining bytes re-arbitrate, and a new header is sent if `ADD_HEADER` is 1.
- `ReqLast` on a beat that also hits the burst limit: a single release.
- Requests arriving while another client is granted are ignored until IDLE.
- A released client has lowest priority in the next arbitration.
- Reset mid-operation: the partial packet is abandoned. Bytes already written to `uart_tx` remain there.

**Reset values**
- State IDLE, `Grant = 0`, `Busy = 0`, `rrPtr = 0`, `burstCnt = 0`.
- Therefore `TxFifoLoad = 0`, `ReqReady = 0`, `TxData = 8'h00`.

## Timing
- Request-to-first-FIFO-write latency:
  - With `ADD_HEADER = 1`: 1 cycle in IDLE for arbitration, then the header write in the next cycle if the FIFO is not full.
  - With `ADD_HEADER = 0`: the first data beat can be accepted on the cycle after the request is seen.
- Throughput: one byte per cycle while the FIFO is not full.
- Idle gap between grants: exactly 1 cycle (the IDLE cycle).
- Effect of `TxFifoFull` deassertion: the stalled write completes in the same cycle, with no added latency.

## Test plan
- **Single client, header on.** Client 2 sends `8'h11, 8'h22, 8'h33` with last on `8'h33`. FIFO receives `A2, 11, 22, 33`. `Grant = 4'b0100` for 4 cycles, then 0.
- **Round-robin rotation.** All four clients send continuous 1-byte packets, each with last. Header bytes appear in order `A0, A1, A2, A3, A0`. No client is granted twice before the others.
- **Burst limit.** `MAX_BURST = 4`; client 1 sends 10 bytes with last on byte 10.
  - Client 1 alone: FIFO sees `A1` + 4 bytes, `A1` + 4 bytes, `A1` + 2 bytes.
  - Client 0 competing: client 0 is served between client 1's bursts.
- **Back-pressure.** Hold `TxFifoFull` high for 5 cycles mid-packet, including once during HEADER. No loads occur, `ReqReady` is 0, and no byte is lost or duplicated.
- **Stalled owner.** Granted client 3 drops `ReqValid` for 20 cycles while client 0 requests. Grant stays with client 3. Client 0 is granted 1 cycle after client 3's last beat.
- **Reset mid-packet.** Assert `reset` during STREAM. Outputs are immediately 0 / idle. After release, arbitration restarts with `rrPtr = 0`: client 0 wins over client 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx FIFO write port
// among NUM_CLIENTS byte streams, with an optional per-grant source tag byte.
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int MAX_BURST   = 64,
  parameter bit ADD_HEADER  = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CLIENTS-1:0]   ReqValid,
  input  logic [8*NUM_CLIENTS-1:0] ReqData,
  input  logic [NUM_CLIENTS-1:0]   ReqLast,
  output logic [NUM_CLIENTS-1:0]   ReqReady,
  input  logic                     TxFifoFull,
  output logic                     TxFifoLoad,
  output logic [7:0]               TxData,
  output logic [NUM_CLIENTS-1:0]   Grant,
  output logic                     Busy
);

  localparam int IW  = $clog2(NUM_CLIENTS);
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;

  logic                   found;
  logic [IW-1:0]          winner;
  logic [IW:0]            cand;

  // First requester at or after rr_ptr_q, wrapping modulo NUM_CLIENTS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = {1'b0, rr_ptr_q} + IW1'(k);
      if (cand >= IW1'(NUM_CLIENTS)) cand = cand - IW1'(NUM_CLIENTS);
      if (!found && ReqValid[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ReqReady    = '0;
    TxFifoLoad  = 1'b0;
    TxData      = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d     = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << winner;
          gidx_d      = winner;
          rr_ptr_d    = (winner == IW'(NUM_CLIENTS-1)) ? '0 : winner + IW'(1);
          burst_cnt_d = 8'd0;
          state_d     = ADD_HEADER ? S_HEADER : S_STREAM;
        end
      end
      S_HEADER: begin
        TxData     = 8'hA0 | 8'(gidx_q);
        TxFifoLoad = ~TxFifoFull;
        if (!TxFifoFull) state_d = S_STREAM;
      end
      S_STREAM: begin
        // Ready depends only on the FIFO flag so ReqValid never loops back into ReqReady.
        ReqReady[gidx_q] = ~TxFifoFull;
        TxData           = ReqData[{gidx_q, 3'b000} +: 8];
        TxFifoLoad       = ReqValid[gidx_q] & ~TxFifoFull;
        if (TxFifoLoad) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (ReqLast[gidx_q] || burst_cnt_q == 8'(MAX_BURST-1)) begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign Grant = grant_q;
  assign Busy  = |grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-client expected byte queues and a
// transaction-level arbitration model checked by an independent monitor.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam bit AH = 1'b1;

  logic             clock, reset;
  logic [N-1:0]     ReqValid, ReqLast, ReqReady, Grant;
  logic [8*N-1:0]   ReqData;
  logic             TxFifoFull, TxFifoLoad, Busy;
  logic [7:0]       TxData;

  uart_tx_arbiter #(.NUM_CLIENTS(N), .MAX_BURST(MB), .ADD_HEADER(AH)) dut (
    .clock(clock), .reset(reset),
    .ReqValid(ReqValid), .ReqData(ReqData), .ReqLast(ReqLast), .ReqReady(ReqReady),
    .TxFifoFull(TxFifoFull), .TxFifoLoad(TxFifoLoad), .TxData(TxData),
    .Grant(Grant), .Busy(Busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [8:0] drv_q[N][$];
  logic [8:0] exp_q[N][$];
  logic [N-1:0] stall;
  int gap_pct, full_pct;
  bit rand_full;
  int n_cmp, n_err;
  int owner, ptr, burst;
  bit need_hdr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int c, input logic [7:0] b, input bit last);
    drv_q[c].push_back({last, b});
    exp_q[c].push_back({last, b});
  endtask

  task automatic push_pkt(input int c, input int len);
    for (int j = 0; j < len; j++) push_byte(c, 8'($urandom), j == len - 1);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string nm, input int limit);
    int cyc;
    cyc = 0;
    while ((!all_empty() || owner >= 0) && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    chk(nm, (cyc >= limit) ? 32'd1 : 32'd0, 32'd0);
    repeat (2) @(negedge clock);
  endtask

  // Client drivers: present queue heads, pop on an accepted beat.
  initial begin : drv
    logic [N-1:0] acc;
    logic [8:0]   e;
    acc = '0;
    ReqValid = '0; ReqData = '0; ReqLast = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < N; i++)
        if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
      if (rand_full) TxFifoFull = ($urandom_range(99) < full_pct);
      for (int i = 0; i < N; i++) begin
        if (drv_q[i].size() > 0 && !stall[i] && $urandom_range(99) >= gap_pct) begin
          e = drv_q[i][0];
          ReqValid[i] = 1'b1;
          ReqData[8*i +: 8] = e[7:0];
          ReqLast[i] = e[8];
        end else begin
          ReqValid[i] = 1'b0;
          ReqData[8*i +: 8] = 8'($urandom);
          ReqLast[i] = 1'($urandom_range(1));
        end
      end
      #4;
      acc = reset ? '0 : (ReqValid & ReqReady);
    end
  end

  // Monitor: reference arbitration model plus byte scoreboard.
  initial begin : mon
    logic [8:0]   e;
    logic [N-1:0] eg, er;
    logic         el;
    owner = -1; ptr = 0; burst = 0; need_hdr = 1'b0;
    forever begin
      @(negedge clock);
      #4;
      if (reset) begin
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_load", 32'(TxFifoLoad), 0);
        chk("rst_ready", 32'(ReqReady), 0);
        chk("rst_data", 32'(TxData), 0);
        owner = -1; ptr = 0; burst = 0; need_hdr = 1'b0;
      end else begin
        eg = (owner < 0) ? '0 : (N'(1) << owner);
        chk("grant", 32'(Grant), 32'(eg));
        chk("busy", 32'(Busy), (owner >= 0) ? 32'd1 : 32'd0);
        if (owner < 0) begin
          chk("idle_load", 32'(TxFifoLoad), 0);
          chk("idle_ready", 32'(ReqReady), 0);
          chk("idle_data", 32'(TxData), 0);
          for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (owner < 0 && ReqValid[c]) begin
              owner = c; ptr = (c + 1) % N; burst = 0; need_hdr = AH;
            end
          end
        end else begin
          if (need_hdr) begin
            er = '0;
            el = !TxFifoFull;
          end else begin
            er = TxFifoFull ? '0 : eg;
            el = ReqValid[owner] & !TxFifoFull;
          end
          chk("ready", 32'(ReqReady), 32'(er));
          chk("load", 32'(TxFifoLoad), 32'(el));
          if (TxFifoLoad && el) begin
            if (need_hdr) begin
              chk("header", 32'(TxData), 32'(8'hA0 | 8'(owner)));
              need_hdr = 1'b0;
            end else if (exp_q[owner].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL extra_byte: got %0h expected none from client %0d at %0t",
                       TxData, owner, $time);
            end else begin
              e = exp_q[owner].pop_front();
              chk("data", 32'(TxData), 32'(e[7:0]));
              burst++;
              if (e[8] || burst == MB) owner = -1;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    n_cmp = 0; n_err = 0;
    reset = 1'b1; TxFifoFull = 1'b0; stall = '0;
    gap_pct = 0; full_pct = 0; rand_full = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    @(negedge clock);
    push_byte(2, 8'h11, 0); push_byte(2, 8'h22, 0); push_byte(2, 8'h33, 1);
    drain("drain_single", 100);

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) push_byte(c, 8'(16 * c + r), 1);
    drain("drain_rr", 200);

    push_pkt(1, 10);
    drain("drain_burst_alone", 200);
    push_pkt(1, 10);
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(0, 2);
    drain("drain_burst_shared", 300);

    push_pkt(0, 6);
    @(negedge clock);
    TxFifoFull = 1'b1;
    repeat (5) @(negedge clock);
    TxFifoFull = 1'b0;
    repeat (2) @(negedge clock);
    TxFifoFull = 1'b1;
    repeat (5) @(negedge clock);
    TxFifoFull = 1'b0;
    drain("drain_backpressure", 200);

    push_pkt(3, 5);
    repeat (3) @(negedge clock);
    stall[3] = 1'b1;
    push_pkt(0, 2);
    repeat (20) @(negedge clock);
    stall[3] = 1'b0;
    drain("drain_stall", 200);

    push_pkt(2, 8);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    push_pkt(1, 2);
    push_pkt(0, 2);
    drain("drain_after_reset", 200);

    gap_pct = 20; full_pct = 25; rand_full = 1'b1;
    for (int t = 0; t < 40; t++) begin
      push_pkt($urandom_range(N - 1), $urandom_range(7, 1));
      repeat ($urandom_range(10)) @(negedge clock);
    end
    @(negedge clock);
    rand_full = 1'b0;
    TxFifoFull = 1'b0;
    drain("drain_random", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
